// File: rtl/cmd_byte_framer.sv
// Host command framer: hunts for the magic word, gathers four command bytes and
// presents them as one magic/command transfer. Stalled partial frames are aborted.
//
// state | meaning
// HUNT  | shifting bytes through the window looking for MAGIC
// CMD   | collecting the four command bytes, idle timer armed
// OUT   | holding the assembled command until downstream takes it
module cmd_byte_framer #(
  parameter logic [31:0] MAGIC   = 32'hF0AA550F,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_vld,
  output logic        o_byte_rdy,
  output logic [31:0] o_cmd_magic,
  output logic [31:0] o_cmd_command,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic [7:0]  o_err_cnt,
  output logic [15:0] o_cmd_cnt,
  output logic        o_busy
);

  typedef enum logic [1:0] {HUNT, CMD, OUT} state_t;

  localparam logic [15:0] IDLE_LAST = TIMEOUT - 16'd1;

  state_t      state;
  logic [31:0] window;
  logic [2:0]  fill;
  logic [1:0]  idx;
  logic [15:0] idle;
  logic        accept;
  logic [31:0] window_nxt;

  assign accept     = i_byte_vld && o_byte_rdy;
  assign window_nxt = {window[23:0], i_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      window        <= '0;
      fill          <= '0;
      idx           <= '0;
      idle          <= '0;
      o_byte_rdy    <= 1'b1;
      o_cmd_vld     <= 1'b0;
      o_cmd_magic   <= '0;
      o_cmd_command <= '0;
      o_err_cnt     <= '0;
      o_cmd_cnt     <= '0;
      o_busy        <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (accept) begin
            window <= window_nxt;
            idle   <= '0;
            if (fill != 3'd4) fill <= fill + 3'd1;
            // Match is judged on the window including this byte.
            if (fill >= 3'd3 && window_nxt == MAGIC) begin
              state  <= CMD;
              idx    <= '0;
              o_busy <= 1'b1;
            end
          end else if (idle == IDLE_LAST) begin
            fill <= '0;
            idle <= '0;
          end else begin
            idle <= idle + 16'd1;
          end
        end

        CMD: begin
          if (accept) begin
            o_cmd_command <= {o_cmd_command[23:0], i_byte};
            idle          <= '0;
            if (idx == 2'd3) begin
              state       <= OUT;
              idx         <= '0;
              window      <= '0;
              fill        <= '0;
              o_byte_rdy  <= 1'b0;
              o_cmd_vld   <= 1'b1;
              o_cmd_magic <= MAGIC;
            end else begin
              idx <= idx + 2'd1;
            end
          end else if (idle == IDLE_LAST) begin
            state  <= HUNT;
            window <= '0;
            fill   <= '0;
            idx    <= '0;
            idle   <= '0;
            o_busy <= 1'b0;
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
          end else begin
            idle <= idle + 16'd1;
          end
        end

        OUT: begin
          if (i_cmd_rdy) begin
            state       <= HUNT;
            o_cmd_vld   <= 1'b0;
            o_cmd_magic <= '0;
            o_byte_rdy  <= 1'b1;
            o_busy      <= 1'b0;
            o_cmd_cnt   <= o_cmd_cnt + 16'd1;
          end
        end

        default: begin
          state      <= HUNT;
          o_byte_rdy <= 1'b1;
          o_cmd_vld  <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_byte_framer.sv
// Bench for cmd_byte_framer with a short timeout; expected frames, counts and
// abort decisions come from the stimulus itself and the framing rules.
module tb_cmd_byte_framer;

  localparam logic [31:0] MAGIC = 32'hF0AA550F;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_byte;
  logic        i_byte_vld;
  logic        o_byte_rdy;
  logic [31:0] o_cmd_magic;
  logic [31:0] o_cmd_command;
  logic        o_cmd_vld;
  logic        i_cmd_rdy;
  logic [7:0]  o_err_cnt;
  logic [15:0] o_cmd_cnt;
  logic        o_busy;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_err = 8'd0;
  logic [15:0] exp_cnt = 16'd0;

  cmd_byte_framer #(.MAGIC(MAGIC), .TIMEOUT(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .i_byte(i_byte), .i_byte_vld(i_byte_vld),
    .o_byte_rdy(o_byte_rdy), .o_cmd_magic(o_cmd_magic), .o_cmd_command(o_cmd_command),
    .o_cmd_vld(o_cmd_vld), .i_cmd_rdy(i_cmd_rdy), .o_err_cnt(o_err_cnt),
    .o_cmd_cnt(o_cmd_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Drives one byte from a negedge and returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n = 0;
    i_byte = b;
    i_byte_vld = 1'b1;
    do begin
      acc = o_byte_rdy;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    i_byte_vld = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_byte_bound: byte %02h not accepted within 100 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sat_inc_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_byte = '0; i_byte_vld = 1'b0; i_cmd_rdy = 1'b1;
    idle(2);
    checks++; if (o_byte_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", o_byte_rdy); end
    checks++; if (o_cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", o_cmd_vld); end
    checks++; if (o_cmd_magic !== 32'h0) begin errors++; $display("FAIL reset_magic: got %h want 0", o_cmd_magic); end
    checks++; if (o_cmd_command !== 32'h0) begin errors++; $display("FAIL reset_command: got %h want 0", o_cmd_command); end
    checks++; if (o_err_cnt !== 8'h0) begin errors++; $display("FAIL reset_err: got %0d want 0", o_err_cnt); end
    checks++; if (o_cmd_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", o_cmd_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    send_word(MAGIC);
    send_word(32'h12345678);
    checks++; if (o_cmd_vld !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b want 1", o_cmd_vld); end
    checks++; if (o_cmd_command !== 32'h12345678) begin errors++; $display("FAIL basic_command: got %h want 12345678", o_cmd_command); end
    checks++; if (o_cmd_magic !== MAGIC) begin errors++; $display("FAIL basic_magic: got %h want %h", o_cmd_magic, MAGIC); end
    checks++; if (o_byte_rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_out: got %b want 0", o_byte_rdy); end
    idle(1);
    exp_cnt++;
    checks++; if (o_cmd_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_drop: got %b want 0", o_cmd_vld); end
    checks++; if (o_cmd_cnt !== exp_cnt) begin errors++; $display("FAIL basic_cnt: got %0d want %0d", o_cmd_cnt, exp_cnt); end
    checks++; if (o_cmd_magic !== 32'h0) begin errors++; $display("FAIL basic_magic_clear: got %h want 0", o_cmd_magic); end
  endtask

  task automatic test_overlap();
    logic [7:0] seq [10];
    seq = '{8'h00, 8'hF0, 8'hF0, 8'hAA, 8'h55, 8'h0F, 8'h80, 8'h00, 8'h00, 8'h05};
    foreach (seq[i]) send_byte(seq[i]);
    checks++; if (o_cmd_vld !== 1'b1 || o_cmd_command !== 32'h80000005) begin
      errors++; $display("FAIL overlap_cmd: vld=%b cmd=%h want 1/80000005", o_cmd_vld, o_cmd_command);
    end
    idle(1);
    exp_cnt++;
    checks++; if (o_err_cnt !== exp_err || o_cmd_cnt !== exp_cnt) begin
      errors++; $display("FAIL overlap_counts: err=%0d cnt=%0d want %0d/%0d", o_err_cnt, o_cmd_cnt, exp_err, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    send_word(MAGIC);
    i_cmd_rdy = 1'b0;
    send_word(32'hCAFE0123);
    i_byte = 8'hF0; i_byte_vld = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_byte_rdy !== 1'b0 || o_cmd_vld !== 1'b1 || o_cmd_command !== 32'hCAFE0123) bad++;
      idle(1);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles want 0", bad); end
    i_cmd_rdy = 1'b1;
    idle(1);
    exp_cnt++;
    checks++; if (o_cmd_vld !== 1'b0 || o_byte_rdy !== 1'b1 || o_cmd_cnt !== exp_cnt) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b cnt=%0d want 0/1/%0d", o_cmd_vld, o_byte_rdy, o_cmd_cnt, exp_cnt);
    end
    idle(1);
    i_byte_vld = 1'b0;
    // The held F0 must have been taken on that cycle for the rest of the magic to match.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F);
    send_word(32'h0BADBEEF);
    checks++; if (o_cmd_vld !== 1'b1 || o_cmd_command !== 32'h0BADBEEF) begin
      errors++; $display("FAIL bp_next_frame: vld=%b cmd=%h want 1/0badbeef", o_cmd_vld, o_cmd_command);
    end
    idle(1);
    exp_cnt++;
  endtask

  task automatic test_timeout();
    send_word(MAGIC);
    send_byte(8'h11); send_byte(8'h22);
    idle(TMO - 1);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL tmo_early: busy=%b want 1", o_busy); end
    idle(1);
    sat_inc_err();
    checks++; if (o_busy !== 1'b0 || o_err_cnt !== exp_err || o_cmd_vld !== 1'b0) begin
      errors++; $display("FAIL tmo_abort: busy=%b err=%0d vld=%b want 0/%0d/0", o_busy, o_err_cnt, o_cmd_vld, exp_err);
    end
    send_word(MAGIC);
    send_word(32'hA5A5_1234);
    checks++; if (o_cmd_vld !== 1'b1 || o_cmd_command !== 32'hA5A51234) begin
      errors++; $display("FAIL tmo_recover: vld=%b cmd=%h want 1/a5a51234", o_cmd_vld, o_cmd_command);
    end
    idle(1);
    exp_cnt++;
  endtask

  task automatic test_boundary();
    send_word(MAGIC);
    send_byte(8'h9A); send_byte(8'hBC);
    idle(TMO - 1);
    send_byte(8'hDE); send_byte(8'hF1);
    checks++; if (o_cmd_vld !== 1'b1 || o_cmd_command !== 32'h9ABCDEF1 || o_err_cnt !== exp_err) begin
      errors++; $display("FAIL boundary: vld=%b cmd=%h err=%0d want 1/9abcdef1/%0d", o_cmd_vld, o_cmd_command, o_err_cnt, exp_err);
    end
    idle(1);
    exp_cnt++;
  endtask

  task automatic test_back_to_back();
    time t0;
    int  cyc;
    t0 = $time;
    send_word(MAGIC); send_word(32'h01020304);
    send_word(MAGIC); send_word(32'h05060708);
    cyc = int'(($time - t0) / 10);
    checks++; if (cyc != 17) begin errors++; $display("FAIL b2b_cycles: got %0d want 17", cyc); end
    checks++; if (o_cmd_command !== 32'h05060708 || o_cmd_cnt !== exp_cnt + 16'd1) begin
      errors++; $display("FAIL b2b_data: cmd=%h cnt=%0d want 05060708/%0d", o_cmd_command, o_cmd_cnt, exp_cnt + 16'd1);
    end
    idle(1);
    exp_cnt = exp_cnt + 16'd2;
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [31:0] cmd;
    int          k, nb, d;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(0, 5);
      for (int g = 0; g < nb; g++) begin
        idle($urandom_range(0, 20));
        do b = 8'($urandom); while (b == 8'hF0);
        send_byte(b);
      end
      send_word(MAGIC);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
      cmd = '0;
      for (int i = 0; i < k; i++) begin
        idle($urandom_range(0, TMO - 1));
        b = 8'($urandom);
        cmd = {cmd[23:0], b};
        if (i == 3) i_cmd_rdy = 1'b0;
        send_byte(b);
      end
      if (k == 4) begin
        checks++; if (o_cmd_vld !== 1'b1 || o_cmd_command !== cmd || o_cmd_magic !== MAGIC) begin
          errors++; $display("FAIL rand_frame%0d: vld=%b cmd=%h magic=%h want 1/%h/%h", f, o_cmd_vld, o_cmd_command, o_cmd_magic, cmd, MAGIC);
        end
        d = $urandom_range(0, 3);
        idle(d);
        i_cmd_rdy = 1'b1;
        idle(1);
        exp_cnt++;
        checks++; if (o_cmd_vld !== 1'b0 || o_cmd_cnt !== exp_cnt) begin
          errors++; $display("FAIL rand_hs%0d: vld=%b cnt=%0d want 0/%0d", f, o_cmd_vld, o_cmd_cnt, exp_cnt);
        end
      end else begin
        idle(TMO + $urandom_range(0, 4));
        sat_inc_err();
        checks++; if (o_busy !== 1'b0 || o_err_cnt !== exp_err || o_cmd_vld !== 1'b0) begin
          errors++; $display("FAIL rand_abort%0d: busy=%b err=%0d vld=%b want 0/%0d/0", f, o_busy, o_err_cnt, o_cmd_vld, exp_err);
        end
      end
    end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 256; i++) begin
      send_word(MAGIC);
      idle(TMO);
      sat_inc_err();
      if (i == 200) begin
        checks++; if (o_err_cnt !== exp_err) begin errors++; $display("FAIL sat_mid: got %0d want %0d", o_err_cnt, exp_err); end
      end
    end
    checks++; if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_final: got %0d want 255", o_err_cnt); end
  endtask

  task automatic test_reset_out();
    send_word(MAGIC);
    i_cmd_rdy = 1'b0;
    send_word(32'h55667788);
    checks++; if (o_cmd_vld !== 1'b1) begin errors++; $display("FAIL rst_out_pre: vld=%b want 1", o_cmd_vld); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_cmd_vld !== 1'b0 || o_cmd_magic !== 32'h0 || o_cmd_command !== 32'h0) begin
      errors++; $display("FAIL rst_out_async: vld=%b magic=%h cmd=%h want 0/0/0", o_cmd_vld, o_cmd_magic, o_cmd_command);
    end
    checks++; if (o_err_cnt !== 8'h0 || o_cmd_cnt !== 16'h0 || o_busy !== 1'b0 || o_byte_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_out_counts: err=%0d cnt=%0d busy=%b rdy=%b want 0/0/0/1", o_err_cnt, o_cmd_cnt, o_busy, o_byte_rdy);
    end
    i_cmd_rdy = 1'b1;
    idle(1);
    rst_n = 1'b1;
    exp_err = 8'd0; exp_cnt = 16'd0;
    idle(1);
    send_word(MAGIC); send_word(32'h0000C0DE);
    checks++; if (o_cmd_vld !== 1'b1 || o_cmd_command !== 32'h0000C0DE) begin
      errors++; $display("FAIL rst_out_after: vld=%b cmd=%h want 1/0000c0de", o_cmd_vld, o_cmd_command);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_backpressure();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_random();
    test_err_sat();
    test_reset_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
